id_queue_stage: RTL and testbench
=================================

ID_QUEUE_STAGE -- requirements
Module: id_queue_stage

Interface
REQ-001 Parameter IQ_DEPTH, default 4, instruction-queue entries; power of two, >=2.
REQ-002 Parameter NUM_FWD, default 3, bypass sources; index 0 is youngest (EX), then MEM, then WB.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_to_id_valid  input  1  IF offers a packet.
REQ-006 if_to_id_bus  input  64  {ins[31:0], pc[31:0]}.
REQ-007 id_allowin  output  1  queue can accept a push this cycle.
REQ-008 ex_allowin  input  1  EX accepts the head this cycle.
REQ-009 id_to_ex_valid  output  1  head is decoded, hazard-free and offered to EX.
REQ-010 id_to_ex_bus  output  128  {ins, pc, rs1_value, rs2_value}.
REQ-011 rf_raddr1 / rf_raddr2  output  5 each  head rs1/rs2; rf_rdata1 / rf_rdata2  input  32 each  combinational register-file read data.
REQ-012 fwd_bus  input  NUM_FWD*39  per source {wr_valid, data_ready, addr[4:0], data[31:0]}, source i at bits [39i+38:39i].
REQ-013 ext_flush  input  1  discard all queued instructions (trap/redirect from later stage).
REQ-014 bj_wen  output  1  redirect IF this cycle; bj_pc  output  32  redirect target.

Function
REQ-015 Queue is circular FIFO; head/tail pointers log2(IQ_DEPTH) bits wrapping modulo IQ_DEPTH; count 0..IQ_DEPTH.
REQ-016 id_allowin = (count != IQ_DEPTH) & ~rst; no same-cycle pop pass-through when full.
REQ-017 Push = if_to_id_valid & id_allowin; pop = id_to_ex_valid & ex_allowin; simultaneous push and pop leaves count unchanged.
REQ-018 Latency: packet pushed at edge N into an empty queue is at the head, and may raise id_to_ex_valid, in cycle N+1.
REQ-019 Head operand use decoded by opcode: R, S, B use rs1 and rs2; I-calc, load, JALR use rs1 only; LUI, AUIPC, JAL use neither.
REQ-020 Per used operand rs != 0: selected source = lowest index i with wr_valid & addr == rs; value = that source's data; no match -> rf_rdata; rs == 0 -> 0.
REQ-021 Stall (id_to_ex_valid = 0) when the selected source has data_ready = 0; unused operands never stall.
REQ-022 Branches resolve in this stage from forwarded or RF operands, with no extra branch stall: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned).
REQ-023 bj_wen = pop & (taken branch | JAL | JALR); bj_pc = pc+B-imm, pc+J-imm, or (rs1+I-imm) & ~1; bj_pc = 0 when bj_wen = 0.
REQ-024 On a pop with bj_wen = 1: all entries after the head are discarded and any same-cycle push is dropped; count = 0 after the edge.
REQ-025 ext_flush = 1: id_to_ex_valid and bj_wen forced 0 that cycle; queue emptied at the edge; same-cycle push dropped. ext_flush overrides pop and redirect.
REQ-026 id_to_ex_bus content is unspecified while id_to_ex_valid = 0.

Reset
REQ-027 While rst = 1: count, head and tail = 0; id_to_ex_valid = 0; bj_wen = 0; id_allowin = 0.
REQ-028 First cycle after rst deasserts: id_allowin = 1; queue storage is not reset.
REQ-029 Reset asserted mid-operation discards all entries with no EX handoff or redirect in that cycle.

Structure
REQ-030 Shared package/header mycpu.h holds opcode constants, IF_TO_ID_BUS_WD = 64, ID_TO_EX_BUS_WD = 128 and FWD_ENT_WD = 39.
REQ-031 Queue is a sub-module iq_fifo (parameters DEPTH, WIDTH), with push/pop/flush ports and full/empty/head outputs.
REQ-032 Decode, bypass and branch compare are combinational in the top module; the register file is external.

Verification
REQ-033 Depth fill: rst, then 5 pushes with ex_allowin = 0 (IQ_DEPTH = 4) -> id_allowin = 0 after the 4th push; 5th not accepted; ex_allowin = 1 -> 4 pops in order pc 0x0, 0x4, 0x8, 0xC.
REQ-034 Bypass priority: head ADD x3,x1,x2; src0 {1,1,x1,0x11} and src2 {1,1,x1,0x33}, x2 from RF = 0x5 -> rs1_value = 0x11, rs2_value = 0x5.
REQ-035 Load-use stall: src0 {1,0,x1,-} with head using x1 -> id_to_ex_valid = 0; next cycle src0 data_ready = 1, data 0x7 -> valid with rs1_value = 0x7.
REQ-036 Branch flush: queue {BEQ x1,x1,+16 @0x100, 3 younger}, ex_allowin = 1 -> bj_wen = 1, bj_pc = 0x110, count = 0 next cycle, concurrent push dropped.
REQ-037 JALR alignment: rs1 = 0x2003, imm = 0 -> bj_pc = 0x2002; ext_flush together with this pop -> bj_wen = 0, queue empty.
REQ-038 Wrap-around: 10 interleaved pushes/pops at depth 4 -> FIFO order preserved across pointer wrap; rst mid-stream -> id_to_ex_valid = 0, count = 0.

Source files
------------

// File: rtl/id_queue_stage_pkg.sv
// Shared decode constants, bus widths and packet layouts for the ID queue stage.
// Combinational helpers only; no state.
package id_queue_stage_pkg;

    localparam int IF_TO_ID_BUS_WD = 64;
    localparam int ID_TO_EX_BUS_WD = 128;
    localparam int FWD_ENT_WD      = 39;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } if_pkt_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
    } ex_pkt_t;

    typedef struct packed {
        logic        wr_valid;
        logic        data_ready;
        logic [4:0]  addr;
        logic [31:0] data;
    } fwd_ent_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/id_queue_stage_if.sv
// IF->ID->EX handshake, register-file read port, bypass bus and redirect signals.
// master = surrounding pipeline, slave = the ID queue stage.
interface id_queue_stage_if import id_queue_stage_pkg::*; #(
    parameter int NUM_FWD = 3
) ();
    logic                            if_to_id_valid;
    logic [IF_TO_ID_BUS_WD-1:0]      if_to_id_bus;
    logic                            id_allowin;
    logic                            ex_allowin;
    logic                            id_to_ex_valid;
    logic [ID_TO_EX_BUS_WD-1:0]      id_to_ex_bus;
    logic [4:0]                      rf_raddr1;
    logic [4:0]                      rf_raddr2;
    logic [31:0]                     rf_rdata1;
    logic [31:0]                     rf_rdata2;
    logic [NUM_FWD*FWD_ENT_WD-1:0]   fwd_bus;
    logic                            ext_flush;
    logic                            bj_wen;
    logic [31:0]                     bj_pc;

    modport master (
        output if_to_id_valid, if_to_id_bus, ex_allowin, rf_rdata1, rf_rdata2, fwd_bus, ext_flush,
        input  id_allowin, id_to_ex_valid, id_to_ex_bus, rf_raddr1, rf_raddr2, bj_wen, bj_pc
    );

    modport slave (
        input  if_to_id_valid, if_to_id_bus, ex_allowin, rf_rdata1, rf_rdata2, fwd_bus, ext_flush,
        output id_allowin, id_to_ex_valid, id_to_ex_bus, rf_raddr1, rf_raddr2, bj_wen, bj_pc
    );
endinterface

// File: rtl/id_queue_stage_iq_fifo.sv
// Circular instruction queue: push visible at head one cycle later, flush empties at the edge.
// Push is ignored when full and pop when empty; no same-cycle pass-through.
module iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_head];
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_tail] <= i_push_dat;
    end
endmodule

// File: rtl/id_queue_stage.sv
// Decode stage behind an instruction queue: bypass, load-use stall, in-stage branch resolve.
// Head offered to EX one cycle after push; holds while EX stalls; redirect/flush empty the queue.
module id_queue_stage import id_queue_stage_pkg::*; #(
    parameter int IQ_DEPTH = 4,
    parameter int NUM_FWD  = 3
) (
    input  logic          clk,
    input  logic          rst,
    id_queue_stage_if.slave bus
);
    if_pkt_t     w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_valid;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_taken;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_rs1_rdy;
    logic        w_rs2_rdy;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    fwd_ent_t    w_fwd [NUM_FWD];
    ex_pkt_t     w_ex_pkt;

    iq_fifo #(.DEPTH(IQ_DEPTH), .WIDTH(IF_TO_ID_BUS_WD)) u_iq_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (w_push),
        .i_push_dat (bus.if_to_id_bus),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head_dat (w_head)
    );

    assign w_opcode = w_head.ins[6:0];
    assign w_funct3 = w_head.ins[14:12];
    assign w_rs1    = w_head.ins[19:15];
    assign w_rs2    = w_head.ins[24:20];

    always_comb begin
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        case (w_opcode)
            OP_OP, OP_STORE: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_BRANCH:       begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_is_branch = 1'b1; end
            OP_OPIMM, OP_LOAD: w_use_rs1 = 1'b1;
            OP_JALR:         begin w_use_rs1 = 1'b1; w_is_jalr = 1'b1; end
            OP_JAL:          w_is_jal = 1'b1;
            default:         ;
        endcase
    end

    // Lowest source index wins, so the youngest in-flight writer supplies the value.
    always_comb begin
        w_rs1_val = bus.rf_rdata1;
        w_rs2_val = bus.rf_rdata2;
        w_rs1_rdy = 1'b1;
        w_rs2_rdy = 1'b1;
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            w_fwd[i] = bus.fwd_bus[i*FWD_ENT_WD +: FWD_ENT_WD];
            if (!w_rs1_hit && w_fwd[i].wr_valid && w_fwd[i].addr == w_rs1) begin
                w_rs1_hit = 1'b1;
                w_rs1_val = w_fwd[i].data;
                w_rs1_rdy = w_fwd[i].data_ready;
            end
            if (!w_rs2_hit && w_fwd[i].wr_valid && w_fwd[i].addr == w_rs2) begin
                w_rs2_hit = 1'b1;
                w_rs2_val = w_fwd[i].data;
                w_rs2_rdy = w_fwd[i].data_ready;
            end
        end
        if (w_rs1 == 5'd0) begin
            w_rs1_val = '0;
            w_rs1_rdy = 1'b1;
        end
        if (w_rs2 == 5'd0) begin
            w_rs2_val = '0;
            w_rs2_rdy = 1'b1;
        end
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
            3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        if (w_is_branch)   w_target = w_head.pc + imm_b(w_head.ins);
        else if (w_is_jal) w_target = w_head.pc + imm_j(w_head.ins);
        else               w_target = (w_rs1_val + imm_i(w_head.ins)) & ~32'd1;
    end

    assign w_stall    = (w_use_rs1 & ~w_rs1_rdy) | (w_use_rs2 & ~w_rs2_rdy);
    assign w_valid    = ~w_empty & ~rst & ~bus.ext_flush & ~w_stall;
    assign w_pop      = w_valid & bus.ex_allowin;
    assign w_redirect = w_pop & ((w_is_branch & w_taken) | w_is_jal | w_is_jalr);
    assign w_flush    = bus.ext_flush | w_redirect;
    assign w_push     = bus.if_to_id_valid & bus.id_allowin & ~w_flush;

    assign w_ex_pkt = '{ins: w_head.ins, pc: w_head.pc, rs1_value: w_rs1_val, rs2_value: w_rs2_val};

    assign bus.id_allowin     = ~w_full & ~rst;
    assign bus.id_to_ex_valid = w_valid;
    assign bus.id_to_ex_bus   = w_ex_pkt;
    assign bus.rf_raddr1      = w_rs1;
    assign bus.rf_raddr2      = w_rs2;
    assign bus.bj_wen         = w_redirect;
    assign bus.bj_pc          = w_redirect ? w_target : 32'd0;
endmodule

// File: tb/tb_id_queue_stage.sv
// Directed bench for id_queue_stage: fill, bypass, stalls, redirects, flush, wrap and reset.
module tb_id_queue_stage;
    import id_queue_stage_pkg::*;

    localparam int DEPTH = 4;
    localparam int NF    = 3;

    localparam logic [31:0] NOP  = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] ADD  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] ADDI = 32'h0000_8213; // addi x4,x1,0
    localparam logic [31:0] LUI  = 32'h0000_80B7; // lui  x1,0x8 (rs1 field = 1, unused)
    localparam logic [31:0] BEQ  = 32'h0010_8863; // beq  x1,x1,+16
    localparam logic [31:0] BNE  = 32'h0010_9863; // bne  x1,x1,+16
    localparam logic [31:0] JAL  = 32'h0080_006F; // jal  x0,+8
    localparam logic [31:0] JALR = 32'h0002_8067; // jalr x0,0(x5)

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_queue_stage_if #(.NUM_FWD(NF)) u_if ();

    id_queue_stage #(.IQ_DEPTH(DEPTH), .NUM_FWD(NF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    logic [31:0] rf [32];
    assign u_if.rf_rdata1 = rf[u_if.rf_raddr1];
    assign u_if.rf_rdata2 = rf[u_if.rf_raddr2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] fwd(input logic wv, input logic dr, input logic [4:0] a,
                                        input logic [31:0] d);
        return {wv, dr, a, d};
    endfunction

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        u_if.if_to_id_valid = 1'b1;
        u_if.if_to_id_bus   = {ins, pc};
        tick();
        u_if.if_to_id_valid = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        u_if.if_to_id_valid = 1'b0;
        u_if.if_to_id_bus   = '0;
        u_if.ex_allowin     = 1'b0;
        u_if.fwd_bus        = '0;
        u_if.ext_flush      = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        tick();
        tick();
        check("rst_allowin", u_if.id_allowin, 0);
        check("rst_valid", u_if.id_to_ex_valid, 0);
        check("rst_bj_wen", u_if.bj_wen, 0);
        check("rst_count", dut.u_iq_fifo.r_count, 0);
        rst = 1'b0;
        #1;
        check("post_rst_allowin", u_if.id_allowin, 1);

        // Depth fill: five offers, four accepted, then drain in order.
        for (int k = 0; k < 5; k++) begin
            u_if.if_to_id_valid = 1'b1;
            u_if.if_to_id_bus   = {NOP, 32'(4 * k)};
            tick();
            if (k == 3) check("full_allowin", u_if.id_allowin, 0);
        end
        u_if.if_to_id_valid = 1'b0;
        #1;
        check("full_count", dut.u_iq_fifo.r_count, 4);
        u_if.ex_allowin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_valid", u_if.id_to_ex_valid, 1);
            check("drain_pc", u_if.id_to_ex_bus[95:64], 32'(4 * k));
            tick();
        end
        u_if.ex_allowin = 1'b0;
        #1;
        check("drain_empty", u_if.id_to_ex_valid, 0);

        // Bypass priority: source 0 beats source 2; x2 comes from the RF.
        rf[1] = 32'h99;
        rf[2] = 32'h5;
        u_if.fwd_bus = {fwd(1, 1, 5'd1, 32'h33), fwd(0, 0, 5'd0, 32'h0), fwd(1, 1, 5'd1, 32'h11)};
        push_one(ADD, 32'h40);
        #1;
        check("byp_valid", u_if.id_to_ex_valid, 1);
        check("byp_rs1", u_if.id_to_ex_bus[63:32], 32'h11);
        check("byp_rs2", u_if.id_to_ex_bus[31:0], 32'h5);
        u_if.ex_allowin = 1'b1;
        tick();
        u_if.ex_allowin = 1'b0;

        // Load-use stall, released when the data becomes ready.
        u_if.fwd_bus = {fwd(0, 0, 5'd0, 32'h0), fwd(0, 0, 5'd0, 32'h0), fwd(1, 0, 5'd1, 32'h0)};
        push_one(ADDI, 32'h50);
        #1;
        check("lu_stall", u_if.id_to_ex_valid, 0);
        tick();
        u_if.fwd_bus = {fwd(0, 0, 5'd0, 32'h0), fwd(0, 0, 5'd0, 32'h0), fwd(1, 1, 5'd1, 32'h7)};
        #1;
        check("lu_release", u_if.id_to_ex_valid, 1);
        check("lu_rs1", u_if.id_to_ex_bus[63:32], 32'h7);
        u_if.ex_allowin = 1'b1;
        tick();
        u_if.ex_allowin = 1'b0;

        // LUI does not read rs1, so a pending x1 writer must not stall it.
        u_if.fwd_bus = {fwd(0, 0, 5'd0, 32'h0), fwd(0, 0, 5'd0, 32'h0), fwd(1, 0, 5'd1, 32'h0)};
        push_one(LUI, 32'h60);
        #1;
        check("lui_nostall", u_if.id_to_ex_valid, 1);
        u_if.ex_allowin = 1'b1;
        tick();
        u_if.ex_allowin = 1'b0;
        u_if.fwd_bus    = '0;

        // Not-taken branch pops normally with no redirect.
        push_one(BNE, 32'h180);
        u_if.ex_allowin = 1'b1;
        #1;
        check("bne_valid", u_if.id_to_ex_valid, 1);
        check("bne_bj_wen", u_if.bj_wen, 0);
        check("bne_bj_pc", u_if.bj_pc, 0);
        tick();
        u_if.ex_allowin = 1'b0;
        #1;
        check("bne_count", dut.u_iq_fifo.r_count, 0);

        // Taken BEQ with three younger entries: redirect and discard.
        push_one(BEQ, 32'h100);
        push_one(NOP, 32'h104);
        push_one(NOP, 32'h108);
        push_one(NOP, 32'h10C);
        u_if.if_to_id_valid = 1'b1;
        u_if.if_to_id_bus   = {NOP, 32'h200};
        u_if.ex_allowin     = 1'b1;
        #1;
        check("beq_bj_wen", u_if.bj_wen, 1);
        check("beq_bj_pc", u_if.bj_pc, 32'h110);
        tick();
        u_if.if_to_id_valid = 1'b0;
        u_if.ex_allowin     = 1'b0;
        #1;
        check("beq_count", dut.u_iq_fifo.r_count, 0);
        check("beq_valid", u_if.id_to_ex_valid, 0);

        // JAL with a concurrent push that must be dropped.
        push_one(JAL, 32'h200);
        u_if.if_to_id_valid = 1'b1;
        u_if.if_to_id_bus   = {NOP, 32'h300};
        u_if.ex_allowin     = 1'b1;
        #1;
        check("jal_bj_wen", u_if.bj_wen, 1);
        check("jal_bj_pc", u_if.bj_pc, 32'h208);
        tick();
        u_if.if_to_id_valid = 1'b0;
        u_if.ex_allowin     = 1'b0;
        #1;
        check("jal_count", dut.u_iq_fifo.r_count, 0);

        // JALR target alignment, then ext_flush overriding the redirect.
        rf[5] = 32'h2003;
        push_one(JALR, 32'h400);
        push_one(NOP, 32'h404);
        u_if.ex_allowin = 1'b1;
        #1;
        check("jalr_bj_wen", u_if.bj_wen, 1);
        check("jalr_bj_pc", u_if.bj_pc, 32'h2002);
        u_if.ext_flush = 1'b1;
        #1;
        check("xf_bj_wen", u_if.bj_wen, 0);
        check("xf_valid", u_if.id_to_ex_valid, 0);
        check("xf_bj_pc", u_if.bj_pc, 0);
        tick();
        u_if.ext_flush  = 1'b0;
        u_if.ex_allowin = 1'b0;
        #1;
        check("xf_count", dut.u_iq_fifo.r_count, 0);

        // Wrap-around: ten pushes, pops start once two entries are queued.
        for (int c = 0; c < 10; c++) begin
            u_if.if_to_id_valid = 1'b1;
            u_if.if_to_id_bus   = {NOP, 32'h1000 + 32'(4 * c)};
            u_if.ex_allowin     = (c >= 2);
            #1;
            if (c >= 2) begin
                check("wrap_valid", u_if.id_to_ex_valid, 1);
                check("wrap_pc", u_if.id_to_ex_bus[95:64], 32'h1000 + 32'(4 * (c - 2)));
            end
            tick();
        end
        u_if.if_to_id_valid = 1'b0;
        u_if.ex_allowin     = 1'b0;
        #1;
        check("wrap_count", dut.u_iq_fifo.r_count, 2);
        check("wrap_head_pc", u_if.id_to_ex_bus[95:64], 32'h1020);

        // Reset mid-stream: no handoff that cycle, queue empty afterwards.
        rst             = 1'b1;
        u_if.ex_allowin = 1'b1;
        #1;
        check("mrst_valid", u_if.id_to_ex_valid, 0);
        check("mrst_bj_wen", u_if.bj_wen, 0);
        tick();
        rst             = 1'b0;
        u_if.ex_allowin = 1'b0;
        #1;
        check("mrst_count", dut.u_iq_fifo.r_count, 0);
        check("mrst_after_valid", u_if.id_to_ex_valid, 0);
        check("mrst_allowin", u_if.id_allowin, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
